bcd_updown_counter: RTL and testbench

//  Parametrised N-digit packed-BCD up/down counter for display/decoder paths.
//  - Counts directly in BCD with a per-digit decade carry/borrow chain; no binary count, no divide/modulo.
//  - Adds sync clear, parallel load with digit validation, direction control, wrap/saturate mode and status flags.
//  - Sits between control logic and 7-segment/BCD decoder stages; drives their digit inputs directly.

---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_updown_counter.sv | 75 +++++++
 tb/tb_bcd_updown_counter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and the digit-legality check used by the counter.
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: stores a digit and ripples carry/borrow to the next decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             step_in,
  input  logic             up_dn,
  input  logic             hold_all,
  output logic [BCD_W-1:0] q,
  output logic             step_out
);

  logic [BCD_W-1:0] r_q;
  logic             w_at_end;

  // A digit at its end value (9 going up, 0 going down) rolls over and passes the step on.
  assign w_at_end = up_dn ? (r_q == BCD_MAX) : (r_q == BCD_ZERO);
  assign step_out = step_in & w_at_end;
  assign q        = r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= BCD_ZERO;
    end else if (clear) begin
      r_q <= BCD_ZERO;
    end else if (load) begin
      r_q <= load_d;
    end else if (step_in && !hold_all) begin
      if (up_dn) begin
        r_q <= w_at_end ? BCD_ZERO : r_q + 4'd1;
      end else begin
        r_q <= w_at_end ? BCD_MAX : r_q - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with clear, validated load, wrap/saturate and status flags.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  wrap_p,
  output logic                  load_err
);

  logic              w_load_valid;
  logic              w_load_ok;
  logic [DIGITS:0]   w_step;
  logic              w_terminal;
  logic              w_hold_all;
  logic [4*DIGITS-1:0] w_bcd;
  logic              r_wrap_p;
  logic              r_load_err;

  always_comb begin
    w_load_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      w_load_valid = w_load_valid & bcd_digit_valid(load_val[i*BCD_W +: BCD_W]);
    end
  end

  // Any load request, accepted or not, suppresses counting on that edge.
  assign w_load_ok  = load & ~clear & w_load_valid;
  assign w_step[0]  = enable & ~load & ~clear;
  assign w_terminal = w_step[DIGITS];
  assign w_hold_all = w_terminal & ~WRAP;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .load     (w_load_ok),
      .load_d   (load_val[g*BCD_W +: BCD_W]),
      .step_in  (w_step[g]),
      .up_dn    (up_dn),
      .hold_all (w_hold_all),
      .q        (w_bcd[g*BCD_W +: BCD_W]),
      .step_out (w_step[g+1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap_p   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap_p   <= w_terminal & WRAP;
      r_load_err <= load & ~clear & ~w_load_valid;
    end
  end

  assign bcd      = w_bcd;
  assign at_max   = (w_bcd == {DIGITS{BCD_MAX}});
  assign at_zero  = (w_bcd == '0);
  assign wrap_p   = r_wrap_p;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: 3-digit wrap/saturate, 1-digit and 5-digit builds.
module tb_bcd_updown_counter;

  logic        clk;
  logic        reset_n;
  logic        enable, up_dn, clear, load;
  logic [11:0] lv3;
  logic [3:0]  lv1;
  logic [19:0] lv5;

  logic [11:0] bcd_a, bcd_b;
  logic [3:0]  bcd_c;
  logic [19:0] bcd_d;
  logic max_a, zero_a, wrap_a, err_a;
  logic max_b, zero_b, wrap_b, err_b;
  logic max_c, zero_c, wrap_c, err_c;
  logic max_d, zero_d, wrap_d, err_d;

  int n_vec = 0;
  int n_err = 0;

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(lv3), .bcd(bcd_a), .at_max(max_a), .at_zero(zero_a),
    .wrap_p(wrap_a), .load_err(err_a));

  bcd_updown_counter #(.DIGITS(3), .WRAP(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(lv3), .bcd(bcd_b), .at_max(max_b), .at_zero(zero_b),
    .wrap_p(wrap_b), .load_err(err_b));

  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) u_c (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(lv1), .bcd(bcd_c), .at_max(max_c), .at_zero(zero_c),
    .wrap_p(wrap_c), .load_err(err_c));

  bcd_updown_counter #(.DIGITS(5), .WRAP(1'b1)) u_d (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(lv5), .bcd(bcd_d), .at_max(max_d), .at_zero(zero_d),
    .wrap_p(wrap_d), .load_err(err_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr, ld, en, ud;
    logic [11:0] lv;
    logic [11:0] eb;
    logic        ew, ee;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  initial begin
    reset_n = 1'b0; enable = 0; up_dn = 0; clear = 0; load = 0;
    lv3 = '0; lv1 = '0; lv5 = '0;
    #12;
    chk("reset_bcd_a", bcd_a, 0);
    chk("reset_zero_a", zero_a, 1);
    chk("reset_max_a", max_a, 0);
    chk("reset_wrap_a", wrap_a, 0);
    chk("reset_err_a", err_a, 0);
    chk("reset_max_c", max_c, 0);
    chk("reset_zero_d", zero_d, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Free-running count up from zero on every build
    enable = 1; up_dn = 1;
    for (int i = 1; i <= 1000; i++) begin
      logic [19:0] e;
      step();
      e = to_bcd(i % 1000);
      chk("s1_bcd_a", bcd_a, e[11:0]);
      chk("s1_wrap_a", wrap_a, (i == 1000));
      chk("s1_zero_a", zero_a, (i % 1000 == 0));
      e = to_bcd((i > 999) ? 999 : i);
      chk("s1_bcd_b", bcd_b, e[11:0]);
      chk("s1_wrap_b", wrap_b, 0);
      e = to_bcd(i % 10);
      chk("s1_bcd_c", bcd_c, e[3:0]);
      chk("s1_wrap_c", wrap_c, (i % 10 == 0));
      chk("s1_bcd_d", bcd_d, to_bcd(i));
      chk("s1_wrap_d", wrap_d, 0);
    end

    // 5-digit terminal wrap in both directions
    enable = 0; load = 1; lv5 = 20'h99998;
    step();
    chk("d_load", bcd_d, 20'h99998);
    load = 0; enable = 1; up_dn = 1;
    step();
    chk("d_up_max", bcd_d, 20'h99999);
    chk("d_at_max", max_d, 1);
    chk("d_nowrap", wrap_d, 0);
    step();
    chk("d_wrap_up", bcd_d, 20'h00000);
    chk("d_wrap_up_p", wrap_d, 1);
    chk("d_wrap_zero", zero_d, 1);
    up_dn = 0;
    step();
    chk("d_wrap_dn", bcd_d, 20'h99999);
    chk("d_wrap_dn_p", wrap_d, 1);
    lv5 = '0;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 12'h010, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h009, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h008, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h999, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h042, 12'h042, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h1A5, 12'h042, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h042, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h555, 12'h555, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h321, 12'h000, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 12'h321, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h322, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h322, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h1A5, 12'h322, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h0F0, 12'h322, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h199, 12'h199, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 12'h200, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h199, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h90A, 12'h000, 1'b0, 1'b1};

    for (int i = 0; i < 21; i++) begin
      clear = tbl[i].clr; load = tbl[i].ld; enable = tbl[i].en; up_dn = tbl[i].ud;
      lv3 = tbl[i].lv;
      step();
      chk($sformatf("tbl%0d_bcd", i), bcd_a, tbl[i].eb);
      chk($sformatf("tbl%0d_wrap", i), wrap_a, tbl[i].ew);
      chk($sformatf("tbl%0d_err", i), err_a, tbl[i].ee);
      chk($sformatf("tbl%0d_zero", i), zero_a, (tbl[i].eb == 12'h000));
      chk($sformatf("tbl%0d_max", i), max_a, (tbl[i].eb == 12'h999));
    end
    clear = 0;

    // Saturating build holds at both terminals
    load = 1; enable = 0; lv3 = 12'h999;
    step();
    chk("sat_load", bcd_b, 12'h999);
    load = 0; enable = 1; up_dn = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_up_bcd", bcd_b, 12'h999);
      chk("sat_up_max", max_b, 1);
      chk("sat_up_wrap", wrap_b, 0);
      if (i == 0) chk("wrap_contrast_a", wrap_a, 1);
    end
    load = 1; enable = 0; lv3 = 12'h000;
    step();
    load = 0; enable = 1; up_dn = 0;
    step();
    chk("sat_dn_bcd", bcd_b, 12'h000);
    chk("sat_dn_wrap", wrap_b, 0);
    chk("sat_dn_zero", zero_b, 1);

    // Asynchronous reset between edges while flags are active
    load = 1; enable = 0; lv3 = 12'h734;
    step();
    chk("r6_load", bcd_a, 12'h734);
    lv3 = 12'h1A5;
    step();
    chk("r6_err_set", err_a, 1);
    load = 0; enable = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("r6_bcd", bcd_a, 12'h000);
    chk("r6_err", err_a, 0);
    chk("r6_wrap", wrap_a, 0);
    chk("r6_zero", zero_a, 1);
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1; up_dn = 1;
    step();
    chk("r6_resume", bcd_a, 12'h001);
    enable = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
